// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues bytes in a small FIFO and emits them as
// keyboard-style 11-bit frames on registered ps2_clk/ps2_data lines.
module ps2_device_tx #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       clr_overflow,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       frame_done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] w_div_inc;
    logic [3:0]       r_bit;
    logic [3:0]       w_bit_next;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_next;
    logic [9:0]       r_shift;
    logic [9:0]       w_shift_next;
    logic             r_ps2_clk;
    logic             w_clk_next;
    logic             r_ps2_data;
    logic             w_data_next;
    logic             r_frame_done;
    logic             w_done_next;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_div_wrap;
    logic       w_last_bit;
    logic [7:0] w_rd_byte;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_push     = wr_en & ~w_full;
    assign w_rd_byte  = r_mem[r_rd_ptr];
    assign w_div_inc  = r_div + DIV_W'(1);
    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_last_bit = (r_bit == 4'd10);

    // FIFO storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A dropped write takes priority over a same-cycle clear.
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_SEND;
            S_SEND:  if (w_div_wrap && w_last_bit) w_state_next = S_GAP;
            S_GAP:   if (r_gap == GAP_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift register holds {stop, parity, data}; the start bit is driven directly on load.
    always_comb begin
        w_pop        = 1'b0;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_gap_next   = r_gap;
        w_shift_next = r_shift;
        w_clk_next   = 1'b1;
        w_data_next  = r_ps2_data;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_next = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = {1'b1, ~^w_rd_byte, w_rd_byte};
                    w_data_next  = 1'b0;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                end
            end
            S_SEND: begin
                if (w_div_wrap) begin
                    w_div_next = '0;
                    if (w_last_bit) begin
                        w_done_next = 1'b1;
                        w_data_next = 1'b1;
                        w_gap_next  = '0;
                    end else begin
                        w_data_next  = r_shift[0];
                        w_shift_next = {1'b1, r_shift[9:1]};
                        w_bit_next   = r_bit + 4'd1;
                    end
                end else begin
                    w_div_next = w_div_inc;
                    w_clk_next = (w_div_inc < DIV_HALF);
                end
            end
            S_GAP: begin
                w_data_next = 1'b1;
                w_gap_next  = r_gap + GAP_W'(1);
            end
            default: w_data_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_div        <= '0;
            r_bit        <= '0;
            r_gap        <= '0;
            r_shift      <= '1;
            r_ps2_clk    <= 1'b1;
            r_ps2_data   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_div        <= w_div_next;
            r_bit        <= w_bit_next;
            r_gap        <= w_gap_next;
            r_shift      <= w_shift_next;
            r_ps2_clk    <= w_clk_next;
            r_ps2_data   <= w_data_next;
            r_frame_done <= w_done_next;
        end
    end

    assign full       = w_full;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;
    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;

endmodule
